// File: rtl/err_compute_if.sv
// Command/status and A2D handshake bundle for err_compute.
// master: the error block itself; slave: sequencer/A2D side.
interface err_compute_if;
    logic        strt;
    logic [2:0]  chnnl;
    logic        a2d_strt;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        busy;

    modport master (
        input  strt,
        input  cnv_cmplt,
        input  res,
        output chnnl,
        output a2d_strt,
        output err_sat,
        output err_vld,
        output busy
    );

    modport slave (
        output strt,
        output cnv_cmplt,
        output res,
        input  chnnl,
        input  a2d_strt,
        input  err_sat,
        input  err_vld,
        input  busy
    );
endinterface

// File: rtl/err_compute.sv
// Sweeps 8 IR channels through the A2D, forms a signed weighted sum
// and publishes it saturated to 11 bits with a one-clock valid pulse.
module err_compute #(
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    err_compute_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_t             state;
    logic [7:0]         cnt;
    logic signed [16:0] acc;
    logic [2:0]         chnnl;
    logic               a2d_strt;
    logic [10:0]        err_sat;
    logic               err_vld;
    logic               busy;

    logic [16:0]        mag;
    logic signed [16:0] term;
    logic signed [16:0] acc_nxt;
    logic [10:0]        sat;

    // Weight is +/-2^(ch>>1): odd channels subtract.
    always_comb begin
        mag     = {5'b0, bus.res} << chnnl[2:1];
        term    = chnnl[0] ? -signed'(mag) : signed'(mag);
        acc_nxt = acc + term;
    end

    always_comb begin
        sat = acc_nxt[10:0];
        unique case (1'b1)
            (acc_nxt > 17'sd1023):  sat = 11'h3FF;
            (acc_nxt < -17'sd1024): sat = 11'h400;
            default:                sat = acc_nxt[10:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            chnnl    <= '0;
            a2d_strt <= 1'b0;
            err_sat  <= '0;
            err_vld  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            a2d_strt <= 1'b0;
            err_vld  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.strt) begin
                        acc   <= '0;
                        chnnl <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == CNT_LAST) begin
                        a2d_strt <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.cnv_cmplt) begin
                        acc <= acc_nxt;
                        if (chnnl == 3'd7) begin
                            // Saturate from the final sum so
                            // value and valid land together.
                            err_sat <= sat;
                            err_vld <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            chnnl <= chnnl + 3'd1;
                            cnt   <= '0;
                            state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    chnnl <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.chnnl    = chnnl;
    assign bus.a2d_strt = a2d_strt;
    assign bus.err_sat  = err_sat;
    assign bus.err_vld  = err_vld;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_err_compute.sv
// Directed and randomized sweeps of err_compute against a
// behavioural weighted-sum/saturation model.
module tb_err_compute;

    localparam int SETTLE = 4;
    localparam int W [8] = '{1, -1, 2, -2, 4, -4, 8, -8};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   a2d_cnt;
    int   vld_cnt;

    logic [11:0] res_tab [8];
    int          dly_tab [8];

    err_compute_if bus ();

    err_compute #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.a2d_strt) a2d_cnt++;
        if (bus.err_vld)  vld_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] sat_ref(input int s);
        if (s > 1023)  return 11'h3FF;
        if (s < -1024) return 11'h400;
        return s[10:0];
    endfunction

    task automatic set_all(input logic [11:0] v, input int d);
        for (int i = 0; i < 8; i++) begin
            res_tab[i] = v;
            dly_tab[i] = d;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) begin
            res_tab[i] = 12'($urandom);
            dly_tab[i] = int'($urandom_range(2, 6));
        end
    endtask

    // abort_ch >= 0 drops reset during WAIT of that channel.
    task automatic sweep(input bit g_idle, input bit g_req,
                         input bit g_strt, input int abort_ch);
        int          a0;
        int          v0;
        int          n;
        int          s;
        logic [10:0] e;
        s = 0;
        for (int i = 0; i < 8; i++) s += W[i] * int'(res_tab[i]);
        e  = sat_ref(s);
        @(negedge clk);
        a0 = a2d_cnt;
        v0 = vld_cnt;
        bus.strt = 1'b1;
        if (g_idle) begin
            bus.cnv_cmplt = 1'b1;
            bus.res       = 12'hFFF;
        end
        @(negedge clk);
        bus.strt      = 1'b0;
        bus.cnv_cmplt = 1'b0;
        chk("busy_on", 32'(bus.busy), 32'd1);
        for (int ch = 0; ch < 8; ch++) begin
            n = 0;
            while (!bus.a2d_strt && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (!bus.a2d_strt) begin
                chk("req_timeout", 32'd0, 32'd1);
                return;
            end
            chk("settle_cycles", 32'(n), 32'(SETTLE));
            chk("chnnl_seq", 32'(bus.chnnl), 32'(ch));
            if (g_req) begin
                bus.cnv_cmplt = 1'b1;
                bus.res       = 12'hFFF;
            end
            if (ch == abort_ch) begin
                @(negedge clk);
                bus.cnv_cmplt = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                chk("rst_err_sat", 32'(bus.err_sat), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_chnnl", 32'(bus.chnnl), 32'd0);
                chk("rst_a2d", 32'(bus.a2d_strt), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                chk("abort_vld_cnt", 32'(vld_cnt - v0), 32'd0);
                chk("abort_a2d_cnt", 32'(a2d_cnt - a0),
                    32'(abort_ch + 1));
                return;
            end
            for (int k = 0; k < dly_tab[ch] - 1; k++) begin
                @(negedge clk);
                bus.cnv_cmplt = 1'b0;
                bus.strt      = (g_strt && ch == 3 && k == 0);
            end
            bus.cnv_cmplt = 1'b1;
            bus.res       = res_tab[ch];
            @(negedge clk);
            bus.cnv_cmplt = 1'b0;
            bus.strt      = 1'b0;
            bus.res       = 12'($urandom);
        end
        chk("done_vld", 32'(bus.err_vld), 32'd1);
        chk("done_err_sat", 32'(bus.err_sat), 32'(e));
        chk("done_busy", 32'(bus.busy), 32'd1);
        if (g_strt) bus.strt = 1'b1;
        @(negedge clk);
        bus.strt = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_vld", 32'(bus.err_vld), 32'd0);
        chk("idle_chnnl", 32'(bus.chnnl), 32'd0);
        repeat (SETTLE + 4) @(negedge clk);
        chk("held_err_sat", 32'(bus.err_sat), 32'(e));
        chk("a2d_count", 32'(a2d_cnt - a0), 32'd8);
        chk("vld_count", 32'(vld_cnt - v0), 32'd1);
        chk("stay_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        checks        = 0;
        errors        = 0;
        a2d_cnt       = 0;
        vld_cnt       = 0;
        bus.strt      = 1'b0;
        bus.cnv_cmplt = 1'b0;
        bus.res       = '0;
        repeat (3) @(negedge clk);
        chk("reset_chnnl", 32'(bus.chnnl), 32'd0);
        chk("reset_a2d", 32'(bus.a2d_strt), 32'd0);
        chk("reset_err_sat", 32'(bus.err_sat), 32'd0);
        chk("reset_vld", 32'(bus.err_vld), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_all(12'h800, 3);
        sweep(1'b0, 1'b0, 1'b0, -1);

        set_all(12'h000, 3);
        res_tab[6] = 12'h07F;
        sweep(1'b0, 1'b0, 1'b0, -1);

        set_all(12'h000, 3);
        res_tab[6] = 12'hFFF;
        sweep(1'b0, 1'b0, 1'b0, -1);

        set_all(12'h000, 3);
        res_tab[7] = 12'hFFF;
        sweep(1'b0, 1'b0, 1'b0, -1);

        set_all(12'h000, 3);
        res_tab[0] = 12'h100;
        res_tab[1] = 12'h300;
        sweep(1'b0, 1'b0, 1'b0, -1);

        set_rand();
        sweep(1'b0, 1'b1, 1'b1, -1);

        set_rand();
        sweep(1'b1, 1'b0, 1'b0, -1);

        set_all(12'h000, 3);
        res_tab[6] = 12'h07F;
        sweep(1'b0, 1'b0, 1'b0, -1);
        set_rand();
        sweep(1'b0, 1'b0, 1'b0, 5);

        set_rand();
        sweep(1'b0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            set_rand();
            sweep(1'b0, t[0], t[1], -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
